// File: rtl/alu_wb_queue_pkg.sv
// Shared definitions for the ALU writeback queue: opcode bounds, default widths
// and the queued entry layout.
package alu_wb_queue_pkg;

    localparam int ALU_OP_MIN = 1;
    localparam int ALU_OP_MAX = 10;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_W  = 3;

    typedef struct packed {
        logic [DEF_REG_W-1:0]  reg_addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_fwd_match.sv
// Newest-match search over the pending writeback entries, used for forwarding.
// The walk goes oldest to newest, so the last match found is the newest.
module alu_wb_fwd_match
    import alu_wb_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic [DEPTH-1:0][REG_W-1:0]  regs,
    input  logic [DEPTH-1:0][DATA_W-1:0] datas,
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [CNT_W-1:0]             count,
    input  logic [REG_W-1:0]             raddr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (raddr != '0) && (regs[idx] == raddr)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/alu_wb_queue.sv
// In-order writeback FIFO between ALU-op decode and the register-file write port.
// Define ALU_WB_FWD_EN to add a forwarding lookup over pending entries.
module alu_wb_queue
    import alu_wb_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_op,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    output logic [CNT_W-1:0]  count,
    input  logic [REG_W-1:0]  fwd_raddr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    logic [DEPTH-1:0][REG_W-1:0]  mem_reg;
    logic [DEPTH-1:0][DATA_W-1:0] mem_data;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic                         enq;
    logic                         deq;

    assign stall = (count == CNT_W'(DEPTH));
    assign rf_we = (count != '0);
    assign enq   = alu_op && (wb_reg != '0) && !stall;
    assign deq   = rf_we && rf_ready;

    // Head reads 0 while empty so the write port never shows stale storage.
    assign rf_waddr = rf_we ? mem_reg[rd_ptr]  : '0;
    assign rf_wdata = rf_we ? mem_data[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_reg[wr_ptr]  <= wb_reg;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_WB_FWD_EN
    alu_wb_fwd_match #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (DEPTH)
    ) u_fwd_match (
        .regs   (mem_reg),
        .datas  (mem_data),
        .rd_ptr (rd_ptr),
        .count  (count),
        .raddr  (fwd_raddr),
        .hit    (fwd_hit),
        .data   (fwd_data)
    );
`else
    logic unused_fwd_raddr;
    assign unused_fwd_raddr = ^fwd_raddr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_alu_wb_queue.sv
// Directed bench for alu_wb_queue: reset, latency, full/stall, reg-0 filter,
// steady-state wrap, forwarding and mid-operation reset.
module tb_alu_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_op;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        stall;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic [2:0]  count;
    logic [2:0]  fwd_raddr;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    int checks = 0;
    int errors = 0;

    logic [2:0]  exp_regs  [8];
    logic [15:0] exp_datas [8];

    always #5 clk = ~clk;

    alu_wb_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_ready  (rf_ready),
        .count     (count),
        .fwd_raddr (fwd_raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        alu_op    = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        rf_ready  = 1'b0;
        fwd_raddr = '0;
        step();
        rst_n = 1'b1;
        #1;
        check("rst_rf_we",    32'(rf_we),    0);
        check("rst_stall",    32'(stall),    0);
        check("rst_count",    32'(count),    0);
        check("rst_fwd_hit",  32'(fwd_hit),  0);
        check("rst_waddr",    32'(rf_waddr), 0);
        check("rst_wdata",    32'(rf_wdata), 0);
        check("rst_fwd_data", 32'(fwd_data), 0);

        // single entry, one-cycle latency then drained
        alu_op = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234; rf_ready = 1'b1;
        step();
        alu_op = 1'b0;
        #1;
        check("lat_rf_we", 32'(rf_we),    1);
        check("lat_waddr", 32'(rf_waddr), 3);
        check("lat_wdata", 32'(rf_wdata), 32'h1234);
        check("lat_count", 32'(count),    1);
        step();
        check("drain_rf_we", 32'(rf_we), 0);
        check("drain_count", 32'(count), 0);

        // fill to full with the port blocked
        rf_ready = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            alu_op = 1'b1; wb_reg = 3'(r); wb_data = 16'(16'h0100 + r);
            step();
        end
        check("full_count", 32'(count), 4);
        check("full_stall", 32'(stall), 1);
        wb_reg = 3'd5; wb_data = 16'h0105;
        step();
        check("stall_ignored_count", 32'(count),    4);
        check("stall_head_reg",      32'(rf_waddr), 1);
        check("stall_head_data",     32'(rf_wdata), 32'h0101);
        // pop under stall: reg 5 still ignored at this edge
        rf_ready = 1'b1;
        step();
        check("pop1_count", 32'(count),    3);
        check("pop1_stall", 32'(stall),    0);
        check("pop1_head",  32'(rf_waddr), 2);
        step();
        alu_op = 1'b0;
        #1;
        check("pop2_count", 32'(count),    3);
        check("pop2_head",  32'(rf_waddr), 3);
        step();
        check("pop3_head",  32'(rf_waddr), 4);
        step();
        check("pop4_head",  32'(rf_waddr), 5);
        check("pop4_data",  32'(rf_wdata), 32'h0105);
        step();
        check("pop5_count", 32'(count), 0);
        check("pop5_rf_we", 32'(rf_we), 0);

        // register 0 is never queued
        rf_ready = 1'b0; alu_op = 1'b1; wb_reg = 3'd0; wb_data = 16'hDEAD;
        step();
        check("r0_count", 32'(count), 0);
        check("r0_rf_we", 32'(rf_we), 0);

        // count held at 2 with simultaneous push/pop across pointer wrap
        wb_reg = 3'd6; wb_data = 16'h0206;
        step();
        wb_reg = 3'd7; wb_data = 16'h0207;
        step();
        check("steady_count0", 32'(count),    2);
        check("steady_head0",  32'(rf_waddr), 6);
        exp_regs[0] = 3'd6; exp_datas[0] = 16'h0206;
        exp_regs[1] = 3'd7; exp_datas[1] = 16'h0207;
        for (int k = 0; k < 6; k++) begin
            exp_regs[k+2]  = 3'(k + 1);
            exp_datas[k+2] = 16'(16'h0300 + k);
        end
        rf_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wb_reg = 3'(k + 1); wb_data = 16'(16'h0300 + k);
            step();
            check("steady_count", 32'(count),    2);
            check("steady_head",  32'(rf_waddr), 32'(exp_regs[k+1]));
            check("steady_data",  32'(rf_wdata), 32'(exp_datas[k+1]));
        end
        alu_op = 1'b0;
        step();
        check("steady_last_head", 32'(rf_waddr), 32'(exp_regs[7]));
        check("steady_last_data", 32'(rf_wdata), 32'(exp_datas[7]));
        step();
        check("steady_empty", 32'(count), 0);

        // forwarding: newest of two same-register entries wins
        rf_ready = 1'b0; alu_op = 1'b1;
        wb_reg = 3'd2; wb_data = 16'hAAAA;
        step();
        wb_data = 16'hBBBB;
        step();
        wb_reg = 3'd5; wb_data = 16'h5555;
        step();
        alu_op = 1'b0;
        fwd_raddr = 3'd2;
        #1;
        check("fwd_count", 32'(count), 3);
`ifdef ALU_WB_FWD_EN
        check("fwd2_hit",  32'(fwd_hit),  1);
        check("fwd2_data", 32'(fwd_data), 32'hBBBB);
        fwd_raddr = 3'd5; #1;
        check("fwd5_hit",  32'(fwd_hit),  1);
        check("fwd5_data", 32'(fwd_data), 32'h5555);
`else
        check("fwd2_hit",  32'(fwd_hit),  0);
        check("fwd2_data", 32'(fwd_data), 0);
        fwd_raddr = 3'd5; #1;
        check("fwd5_hit",  32'(fwd_hit),  0);
`endif
        fwd_raddr = 3'd4; #1;
        check("fwd4_hit", 32'(fwd_hit), 0);
        fwd_raddr = 3'd0; #1;
        check("fwd0_hit", 32'(fwd_hit), 0);
        check("fwd_head", 32'(rf_waddr), 2);
        check("fwd_head_data", 32'(rf_wdata), 32'hAAAA);

        // reset with three pending entries discards them
        rst_n = 1'b0; rf_ready = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("mrst_count", 32'(count), 0);
        check("mrst_rf_we", 32'(rf_we), 0);
        check("mrst_stall", 32'(stall), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mrst_no_write", 32'(rf_we), 0);
        end
        fwd_raddr = 3'd2; #1;
        check("mrst_fwd_hit", 32'(fwd_hit), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wb_queue.md
Name: alu_wb_queue

Overview:
- Writeback buffer directly downstream of the ALU-op decode unit.
- Captures each retiring ALU result whose final-stage ALU-op flag (stage-5 bit) is set, and queues it in a small in-order FIFO.
- Drains the FIFO into the register-file write port under a ready handshake.
- Raises stall toward the pipeline when full; optionally exposes a forwarding lookup over pending writes.

Parameters:
- DATA_W, 16, width of ALU result / register data
- REG_W, 3, register address width
- DEPTH, 4, queue entries; must be a power of two, at least 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- alu_op  in  1  stage-5 ALU-op flag from the decode unit (opcode 1..10); qualifies the entry
- wb_reg  in  REG_W  destination register of the stage-5 instruction
- wb_data  in  DATA_W  ALU result of the stage-5 instruction
- stall  out  1  queue full; pipeline holds stage 5
- rf_we  out  1  register-file write request
- rf_waddr  out  REG_W  write address
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts the write this cycle
- count  out  log2(DEPTH)+1  current occupancy
- fwd_raddr  in  REG_W  forwarding lookup address
- fwd_hit  out  1  a pending entry targets fwd_raddr
- fwd_data  out  DATA_W  data of the newest matching pending entry

Behaviour:
- Reset: one clock with rst_n=0 clears rd_ptr, wr_ptr and count to 0.
  - After reset: rf_we=0, stall=0, fwd_hit=0.
  - rf_waddr, rf_wdata and fwd_data read 0 while empty.
  - Storage contents need not be cleared.
- Reset mid-operation: all pending entries are discarded, not written. rf_we is 0 in the cycle after the reset edge.
- Enqueue condition: alu_op=1 and wb_reg!=0 and stall=0.
  - Entry {wb_reg, wb_data} is written at wr_ptr on the clock edge.
  - wr_ptr advances modulo DEPTH.
- Register 0 is never written back: alu_op with wb_reg=0 is ignored.
- stall = (count==DEPTH), derived from registered state only.
  - While stall=1, inputs are ignored, including in a cycle where a dequeue also occurs.
  - The pipeline holds stage 5 and re-presents it the next cycle.
- Dequeue side:
  - rf_we = (count!=0); rf_waddr/rf_wdata = entry at rd_ptr, driven combinationally from storage.
  - Head pops when rf_we && rf_ready; rd_ptr advances modulo DEPTH.
  - The head holds stable while rf_ready=0.
- Simultaneous enqueue and dequeue (count not DEPTH): count unchanged, both pointers advance.
- Latency: an entry enqueued at edge N appears on rf_we/rf_waddr/rf_wdata in cycle N+1 at the earliest.
- Ordering: writes retire in strict enqueue order. Two entries to the same register both write, oldest first.
- Count: increments on enqueue-only, decrements on dequeue-only, saturates at neither end.
  - count never exceeds DEPTH.
  - count never underflows, because dequeue requires count!=0.
- Pointer wrap: pointers are log2(DEPTH) bits; full and empty are distinguished by count.

Optional Feature:
- Macro: ALU_WB_FWD_EN.
- Defined:
  - fwd_hit=1 when any valid entry's reg equals fwd_raddr (fwd_raddr!=0).
  - fwd_data is the newest matching entry, i.e. the one closest to wr_ptr-1.
  - Purely combinational over registered storage; the same-cycle incoming wb_data is not searched.
- Not defined:
  - fwd_hit tied 0 and fwd_data tied 0; fwd_raddr unused.
  - No comparators are synthesised.

Decomposition:
- Shared package holds:
  - ALU-op opcode bounds (ALU_OP_MIN=1, ALU_OP_MAX=10)
  - default DATA_W/REG_W
  - wb_entry_t struct {reg, data}
- One natural sub-module: alu_wb_fwd_match, the priority search newest-to-oldest over DEPTH entries. It is instantiated only under ALU_WB_FWD_EN.

Test Plan:
- Reset then alu_op=1, wb_reg=3, wb_data=0x1234, rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234; following cycle rf_we=0, count=0.
- rf_ready=0, enqueue regs 1,2,3,4 on consecutive cycles -> count=4, stall=1. A fifth entry (reg 5) presented under stall is not captured. Then rf_ready=1 -> writes 1,2,3,4 in order, stall drops after the first pop, and reg 5 is then enqueued.
- alu_op=1 with wb_reg=0 -> count stays 0, rf_we stays 0.
- count=2, simultaneous enqueue and dequeue for 6 cycles -> count stays 2; pointers wrap past DEPTH with output order preserved.
- Queue holding reg2=0xAAAA then reg2=0xBBBB (ALU_WB_FWD_EN defined), fwd_raddr=2 -> fwd_hit=1, fwd_data=0xBBBB. Without the macro -> fwd_hit=0.
- rst_n=0 for one cycle with count=3 -> next cycle count=0, rf_we=0, stall=0; no further register-file writes.
